// File: rtl/ksz_io_arbiter_pkg.sv
// Shared definitions for the KSZ8851 register-IO arbiter: engine state
// encodings, owner IDs, arbiter FSM states and the engine command bundle.
package ksz_io_arbiter_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [3:0] {
    ENG_ADDR0  = 4'b0000,
    ENG_ADDR1  = 4'b0001,
    ENG_ADDR2  = 4'b0010,
    ENG_READ0  = 4'b0011,
    ENG_READ1  = 4'b0100,
    ENG_READ2  = 4'b0101,
    ENG_WRITE0 = 4'b0110,
    ENG_WRITE1 = 4'b0111,
    ENG_WRITE2 = 4'b1000,
    ENG_WAIT   = 4'b1001
  } eng_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_INIT = 2'b01,
    OWN_RX   = 2'b10,
    OWN_TX   = 2'b11
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GRANT = 2'b01,
    ARB_DRAIN = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [7:0]  offset;
    logic        length;
    logic        wr;
    logic        newcmd;
    logic        dummy;
    logic [15:0] wdata;
  } eng_cmd_t;

endpackage

// File: rtl/ksz_io_arbiter_if.sv
// Requester and engine command bus for the KSZ8851 register-IO arbiter.
// Handshake: req_* is a level held until gnt_*; gnt_* stays high until the
// owner pulses rel_* or the hold timeout reclaims the bus; rel_* from a
// non-owner is ignored; engine fields are only driven while a gnt_* is high.
interface ksz_io_arbiter_if;

  logic        req_init, req_rx, req_tx;
  logic        rel_init, rel_rx, rel_tx;
  logic        gnt_init, gnt_rx, gnt_tx;

  logic [7:0]  offset_init, offset_rx, offset_tx;
  logic        length_init, length_rx, length_tx;
  logic        wr_init, wr_rx, wr_tx;
  logic        newcmd_init, newcmd_rx, newcmd_tx;
  logic        dummy_init, dummy_rx, dummy_tx;
  logic [15:0] wdata_init, wdata_rx, wdata_tx;

  logic [3:0]  state;
  logic [7:0]  offset;
  logic        length, WR, NewCommand, Dummy_Write;
  logic [15:0] writeData;

  modport slave (
    input  req_init, req_rx, req_tx,
    input  rel_init, rel_rx, rel_tx,
    output gnt_init, gnt_rx, gnt_tx,
    input  offset_init, offset_rx, offset_tx,
    input  length_init, length_rx, length_tx,
    input  wr_init, wr_rx, wr_tx,
    input  newcmd_init, newcmd_rx, newcmd_tx,
    input  dummy_init, dummy_rx, dummy_tx,
    input  wdata_init, wdata_rx, wdata_tx,
    input  state,
    output offset, length, WR, NewCommand, Dummy_Write, writeData
  );

  modport master (
    output req_init, req_rx, req_tx,
    output rel_init, rel_rx, rel_tx,
    input  gnt_init, gnt_rx, gnt_tx,
    output offset_init, offset_rx, offset_tx,
    output length_init, length_rx, length_tx,
    output wr_init, wr_rx, wr_tx,
    output newcmd_init, newcmd_rx, newcmd_tx,
    output dummy_init, dummy_rx, dummy_tx,
    output wdata_init, wdata_rx, wdata_tx,
    output state,
    input  offset, length, WR, NewCommand, Dummy_Write, writeData
  );

endinterface

// File: rtl/ksz_arb_pick.sv
// Winner selection: init has absolute priority; rx and tx alternate on a tie
// using the last-served bit (1 = tx was served last, so rx wins next).
module ksz_arb_pick
  import ksz_io_arbiter_pkg::*;
(
  input  logic   i_req_init,
  input  logic   i_req_rx,
  input  logic   i_req_tx,
  input  logic   i_last_tx,
  output logic   o_valid,
  output owner_t o_winner
);

  always_comb begin
    o_winner = OWN_NONE;
    if (i_req_init) begin
      o_winner = OWN_INIT;
    end else if (i_req_rx && i_req_tx) begin
      o_winner = i_last_tx ? OWN_RX : OWN_TX;
    end else if (i_req_rx) begin
      o_winner = OWN_RX;
    end else if (i_req_tx) begin
      o_winner = OWN_TX;
    end
  end

  assign o_valid = (o_winner != OWN_NONE);

endmodule

// File: rtl/ksz_io_arbiter.sv
// Grants the KSZ8851 register-IO engine to one of init/rx/tx for a whole
// command sequence, muxes the owner's fields to the engine, reclaims on hang.
module ksz_io_arbiter
  import ksz_io_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES  // at least 16
) (
  input  logic            sysclk,
  input  logic            reset,
  ksz_io_arbiter_if.slave bus,
  input  logic            i_clr_flag,
  output logic            o_timeout_pulse,
  output logic            o_timeout_flag,
  output logic [1:0]      o_owner,
  output arb_state_t      o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  owner_t           r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_tx;
  logic             r_timeout_pulse;
  logic             r_timeout_flag;

  logic             w_pick_valid;
  owner_t           w_pick;
  logic             w_owner_rel;
  logic             w_timeout;
  logic             w_granted;
  eng_cmd_t         w_cmd;

  ksz_arb_pick u_pick (
    .i_req_init (bus.req_init),
    .i_req_rx   (bus.req_rx),
    .i_req_tx   (bus.req_tx),
    .i_last_tx  (r_last_tx),
    .o_valid    (w_pick_valid),
    .o_winner   (w_pick)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A release from the owner takes precedence over a coincident timeout, so
  // only a genuine hang raises the timeout pulse and flag.
  always_comb begin
    w_next_state = r_state;
    w_owner_rel  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) w_next_state = ARB_GRANT;
      end
      ARB_GRANT: begin
        case (r_owner)
          OWN_INIT: w_owner_rel = bus.rel_init;
          OWN_RX:   w_owner_rel = bus.rel_rx;
          OWN_TX:   w_owner_rel = bus.rel_tx;
          default:  w_owner_rel = 1'b0;
        endcase
        if (w_owner_rel) begin
          w_next_state = ARB_DRAIN;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = ARB_DRAIN;
          w_timeout    = 1'b1;
        end
      end
      ARB_DRAIN: begin
        if (bus.state == ENG_WAIT) w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_owner         <= OWN_NONE;
      r_cnt           <= '0;
      r_last_tx       <= 1'b1;
      r_timeout_pulse <= 1'b0;
      r_timeout_flag  <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
      if (w_timeout) begin
        r_timeout_flag <= 1'b1;
      end else if (i_clr_flag) begin
        r_timeout_flag <= 1'b0;
      end

      if (r_state == ARB_IDLE && w_pick_valid) begin
        r_owner <= w_pick;
        r_cnt   <= '0;
        if (w_pick == OWN_RX) begin
          r_last_tx <= 1'b0;
        end else if (w_pick == OWN_TX) begin
          r_last_tx <= 1'b1;
        end
      end else if (r_state == ARB_GRANT && w_next_state == ARB_GRANT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_granted = (r_state == ARB_GRANT);

  // Engine fields are zero whenever nobody holds the bus (IDLE, DRAIN, reset).
  always_comb begin
    w_cmd = '0;
    if (w_granted) begin
      case (r_owner)
        OWN_INIT: w_cmd = '{offset: bus.offset_init, length: bus.length_init,
                            wr: bus.wr_init, newcmd: bus.newcmd_init,
                            dummy: bus.dummy_init, wdata: bus.wdata_init};
        OWN_RX:   w_cmd = '{offset: bus.offset_rx, length: bus.length_rx,
                            wr: bus.wr_rx, newcmd: bus.newcmd_rx,
                            dummy: bus.dummy_rx, wdata: bus.wdata_rx};
        OWN_TX:   w_cmd = '{offset: bus.offset_tx, length: bus.length_tx,
                            wr: bus.wr_tx, newcmd: bus.newcmd_tx,
                            dummy: bus.dummy_tx, wdata: bus.wdata_tx};
        default:  w_cmd = '0;
      endcase
    end
  end

  assign bus.offset      = w_cmd.offset;
  assign bus.length      = w_cmd.length;
  assign bus.WR          = w_cmd.wr;
  assign bus.NewCommand  = w_cmd.newcmd;
  assign bus.Dummy_Write = w_cmd.dummy;
  assign bus.writeData   = w_cmd.wdata;

  assign bus.gnt_init = w_granted && (r_owner == OWN_INIT);
  assign bus.gnt_rx   = w_granted && (r_owner == OWN_RX);
  assign bus.gnt_tx   = w_granted && (r_owner == OWN_TX);

  assign o_owner         = w_granted ? r_owner : OWN_NONE;
  assign o_timeout_pulse = r_timeout_pulse;
  assign o_timeout_flag  = r_timeout_flag;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/ksz_io_arbiter.md
# ksz_io_arbiter

Arbitrates the single KSZ8851 register-IO engine among three requesters: the init sequencer, the receive handler and the transmit sequencer. Grants exclusive ownership of the engine command bus for a whole multi-step sequence, muxes the owner's command signals onto the engine, and recovers the bus if an owner hangs. Sits between the HUB sequencers and the low-level register-IO state machine.

## Interface
- TIMEOUT_CYCLES, 4096: max cycles one grant may be held before forced reclaim; minimum 16.
- sysclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_init / req_rx / req_tx  in  1 each  level request for ownership.
- rel_init / rel_rx / rel_tx  in  1 each  release pulse or level; honored only from the current owner.
- gnt_init / gnt_rx / gnt_tx  out  1 each  one-hot-or-zero grant.
- offset_{init,rx,tx}  in  8  requester register offset.
- length_{init,rx,tx}, wr_{init,rx,tx}, newcmd_{init,rx,tx}, dummy_{init,rx,tx}  in  1 each  requester command fields.
- wdata_{init,rx,tx}  in  16  requester write data.
- state  in  4  engine state; Wait = 4'b1001.
- offset  out  8  to engine.
- length, WR, NewCommand, Dummy_Write  out  1 each  to engine.
- writeData  out  16  to engine.
- timeout_pulse  out  1  one-cycle pulse on forced reclaim.
- timeout_flag  out  1  sticky; cleared by clr_flag.
- clr_flag  in  1  clears timeout_flag.
- owner  out  2  00 none, 01 init, 10 rx, 11 tx.

## Operation
- FSM states: IDLE, GRANT, DRAIN.
- IDLE: outputs to engine are forced: NewCommand=0, Dummy_Write=0, WR=0, offset=0, length=0, writeData=0. If any req is high, pick a winner; enter GRANT next cycle with that gnt high.
- Priority: init is absolute. Between rx and tx, use round-robin: a last-served bit, initially tx, so rx wins the first tie. Update it on every rx or tx grant.
- GRANT: engine outputs combinationally follow the owner's inputs. The timeout counter increments each cycle.
  - rel from the owner: go to DRAIN.
  - Counter reaches TIMEOUT_CYCLES-1: go to DRAIN, pulse timeout_pulse, set timeout_flag.
- DRAIN: gnt all 0, engine outputs forced as in IDLE. Return to IDLE when state==Wait, which may be the same cycle DRAIN is entered.
- Bits asserted by a non-owner are ignored, whether rel or req.
- Requests are level-sensitive. A req dropped before grant is not served.
- Simultaneous rel and req from the same owner: the release is honored, and the requester re-competes from IDLE. The round-robin bit then favours the other of rx/tx.
- clr_flag and a timeout in the same cycle: the flag ends set.
- Reset mid-grant: all outputs go to reset values immediately (async), and the FSM returns to IDLE. The engine sees NewCommand=0.

## Timing
- Reset values: gnt_*=0, owner=00, offset=0, length=0, WR=0, NewCommand=0, Dummy_Write=0, writeData=0, timeout_pulse=0, timeout_flag=0, round-robin bit = tx.
- Request-to-grant latency in IDLE: 1 cycle (req sampled at edge N, gnt high after edge N).
- Owner command to engine: 0 cycles (combinational mux on the registered owner).
- Release: rel at edge N means gnt is low after N. Next grant comes after 2 edges minimum (DRAIN, then IDLE, then GRANT) if state==Wait.
- The timeout counter is cleared on entering GRANT. Width is clog2(TIMEOUT_CYCLES); no wrap, because reaching the limit forces exit.

## Structure
- Shared package holds: engine state encodings (Addr0..Wait, with Wait=4'b1001), owner ID constants, and the default TIMEOUT_CYCLES.
- One small sub-module, ksz_arb_pick: combinational 3-way priority plus rx/tx round-robin selection. Everything else stays inline.

## Test plan
- Reset, then req_rx=1 → gnt_rx=1 after 1 edge, owner=10, engine offset equals offset_rx (e.g. 8'h78).
- req_rx and req_tx both high from IDLE, each releasing after 10 cycles → grant order rx, tx, rx, tx.
- req_init asserted while rx owns → rx keeps its grant until rel_rx. Then init is granted over a pending tx.
- Owner never releases, TIMEOUT_CYCLES=16 → DRAIN after 16 GRANT cycles, timeout_pulse for 1 cycle, timeout_flag=1 until clr_flag.
- rel_rx while state=Write1 → NewCommand=0 and gnt cleared immediately. No new grant until state=4'b1001.
- reset low mid-grant with NewCommand=1 → all outputs 0 asynchronously. After release, req_tx is granted within 1 cycle.
